cache_ctrl: RTL and testbench

- Memory-side controller for one direct-mapped cache way: 8 lines of 20 bits, line format {valid, dirty, tag[1:0], data[15:0]}.
- Accepts CPU read/write requests, looks up the way storage and computes hit.
- On a miss, writes back a dirty victim to main RAM and refills from RAM (read) or allocates (write).
- Sits between the processor datapath and the cache-line storage (mem_block 3x20x8) and the main RAM.

---
 rtl/cache_pkg.sv | 21 ++
 rtl/cache_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_cache_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache controller: line field
// positions and controller states.
package cache_pkg;

  localparam int unsigned LINE_W    = 20;
  localparam int unsigned VALID_BIT = 19;
  localparam int unsigned DIRTY_BIT = 18;
  localparam int unsigned TAG_HI    = 17;
  localparam int unsigned TAG_LO    = 16;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StLookup,
    StWriteback,
    StRefill,
    StFill,
    StResp
  } state_e;

endpackage

// File: rtl/cache_ctrl.sv
// Controller for one direct-mapped cache way: lookup, dirty write-back,
// refill from main RAM on read miss and write-allocate on write miss.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned TAG_W   = 2,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    we,
  input  logic [TAG_W+IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0]       wdata,
  output logic                    ready,
  output logic                    done,
  output logic [DATA_W-1:0]       rdata,
  output logic                    hit_o,
  output logic [IDX_W-1:0]        way_addr,
  output logic                    way_we,
  output logic [LINE_W-1:0]       way_din,
  input  logic [LINE_W-1:0]       way_q,
  output logic [TAG_W+IDX_W-1:0]  mem_addr,
  output logic                    mem_we,
  output logic [DATA_W-1:0]       mem_din,
  input  logic [DATA_W-1:0]       mem_dout
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                we_q, we_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                hit_q, hit_d;
  logic [TAG_W-1:0]    vic_tag_q, vic_tag_d;
  logic [DATA_W-1:0]   vic_data_q, vic_data_d;
  logic                hit;

  assign hit   = way_q[VALID_BIT] & (way_q[TAG_HI:TAG_LO] == tag_q);
  assign rdata = rdata_q;
  assign hit_o = hit_q;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wait_cnt_d = wait_cnt_q;
    we_d       = we_q;
    tag_d      = tag_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    hit_d      = hit_q;
    vic_tag_d  = vic_tag_q;
    vic_data_d = vic_data_q;
    ready      = 1'b0;
    done       = 1'b0;
    way_addr   = idx_q;
    way_we     = 1'b0;
    way_din    = '0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_din    = '0;

    unique case (state_q)
      StInit: begin
        way_we     = 1'b1;
        way_addr   = init_cnt_q;
        init_cnt_d = init_cnt_q + IDX_W'(1);
        if (init_cnt_q == '1) state_d = StIdle;
      end
      StIdle: begin
        ready    = 1'b1;
        // Present the index now so way_q is valid during the lookup cycle.
        way_addr = addr[IDX_W-1:0];
        if (req) begin
          we_d    = we;
          tag_d   = addr[TAG_W+IDX_W-1:IDX_W];
          idx_d   = addr[IDX_W-1:0];
          wdata_d = wdata;
          state_d = StLookup;
        end
      end
      StLookup: begin
        hit_d      = hit;
        vic_tag_d  = way_q[TAG_HI:TAG_LO];
        vic_data_d = way_q[DATA_W-1:0];
        wait_cnt_d = '0;
        if (hit) begin
          if (we_q) begin
            way_we  = 1'b1;
            way_din = {1'b1, 1'b1, tag_q, wdata_q};
          end else begin
            rdata_d = way_q[DATA_W-1:0];
          end
          state_d = StResp;
        end else if (way_q[VALID_BIT] && way_q[DIRTY_BIT]) begin
          state_d = StWriteback;
        end else begin
          state_d = we_q ? StFill : StRefill;
        end
      end
      StWriteback: begin
        mem_we     = 1'b1;
        mem_addr   = {vic_tag_q, idx_q};
        mem_din    = vic_data_q;
        wait_cnt_d = '0;
        state_d    = we_q ? StFill : StRefill;
      end
      StRefill: begin
        mem_addr = {tag_q, idx_q};
        if (wait_cnt_q == CNT_W'(MEM_LAT - 1)) begin
          state_d = StFill;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      StFill: begin
        way_we = 1'b1;
        if (we_q) begin
          way_din = {1'b1, 1'b1, tag_q, wdata_q};
        end else begin
          // Address is held so mem_dout stays valid through the fill cycle.
          mem_addr = {tag_q, idx_q};
          way_din  = {1'b1, 1'b0, tag_q, mem_dout};
          rdata_d  = mem_dout;
        end
        state_d = StResp;
      end
      StResp: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StInit;
    endcase

    // Outputs are quiet while reset is held, aborting any write-back in flight.
    if (rst) begin
      ready    = 1'b0;
      done     = 1'b0;
      way_addr = '0;
      way_we   = 1'b0;
      way_din  = '0;
      mem_addr = '0;
      mem_we   = 1'b0;
      mem_din  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
      we_q       <= 1'b0;
      tag_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      hit_q      <= 1'b0;
      vic_tag_q  <= '0;
      vic_data_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      we_q       <= we_d;
      tag_q      <= tag_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      hit_q      <= hit_d;
      vic_tag_q  <= vic_tag_d;
      vic_data_q <= vic_data_d;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl with behavioural way storage and main RAM.
module tb_cache_ctrl;

  localparam int unsigned MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [4:0]  addr;
  logic [15:0] wdata;
  logic        ready;
  logic        done;
  logic [15:0] rdata;
  logic        hit_o;
  logic [2:0]  way_addr;
  logic        way_we;
  logic [19:0] way_din;
  logic [19:0] way_q;
  logic [4:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;

  cache_ctrl #(
    .IDX_W  (3),
    .TAG_W  (2),
    .DATA_W (16),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .ready   (ready),
    .done    (done),
    .rdata   (rdata),
    .hit_o   (hit_o),
    .way_addr(way_addr),
    .way_we  (way_we),
    .way_din (way_din),
    .way_q   (way_q),
    .mem_addr(mem_addr),
    .mem_we  (mem_we),
    .mem_din (mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Way storage: registered read, one cycle after way_addr.
  logic [19:0] ways [8];
  always @(posedge clk) begin
    if (way_we) ways[way_addr] <= way_din;
    way_q <= ways[way_addr];
  end

  // Main RAM: preloaded contents until written, MEM_LAT-deep read pipeline.
  logic [15:0] ram  [32];
  bit          ram_w[32];
  logic [15:0] pipe0, pipe1;

  function automatic logic [15:0] ram_rd(input logic [4:0] a);
    if (ram_w[a]) return ram[a];
    case (a)
      5'h0B:   return 16'h1234;
      5'h1B:   return 16'h5678;
      5'h02:   return 16'hA5A5;
      default: return {11'h078, a};
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr]   <= mem_din;
      ram_w[mem_addr] <= 1'b1;
    end
    pipe0 <= ram_rd(mem_addr);
    pipe1 <= pipe0;
  end
  assign mem_dout = pipe1;

  typedef struct {
    logic [15:0] rdata;
    logic        hit;
    logic        is_rd;
    int          acc;
    int          lat;
  } exp_t;
  typedef struct {
    logic [4:0]  a;
    logic [15:0] d;
  } wb_t;

  exp_t exp_q[$];
  wb_t  wb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboards whenever the DUT completes or writes RAM.
  initial begin
    exp_t e;
    wb_t  w;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && (mem_we || way_we)) chk("we_exclusive", {31'b0, mem_we & way_we}, 32'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("hit_o", {31'b0, hit_o}, {31'b0, e.hit});
          chk("latency", cyc - e.acc + 1, e.lat);
          if (e.is_rd) chk("rdata", {16'b0, rdata}, {16'b0, e.rdata});
        end
      end
      if (mem_we) begin
        if (wb_q.size() == 0) begin
          chk("unexpected_mem_we", 32'd1, 32'd0);
        end else begin
          w = wb_q.pop_front();
          chk("wb_addr", {27'b0, mem_addr}, {27'b0, w.a});
          chk("wb_data", {16'b0, mem_din}, {16'b0, w.d});
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    #1;
    while (!ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || wb_q.size() != 0 || !ready) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_req(input logic w, input logic [4:0] a, input logic [15:0] d,
                        input logic [15:0] er, input logic eh, input int el);
    exp_t e;
    wait_ready();
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    e = '{rdata: er, hit: eh, is_rd: !w, acc: cyc + 1, lat: el};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int   n;
    exp_t e;
    rst   = 1'b1;
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_way_we", {31'b0, way_we}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_rdata", {16'b0, rdata}, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("init_ready", {31'b0, ready}, 32'd0);
      chk("init_way_we", {31'b0, way_we}, 32'd1);
      chk("init_way_addr", {29'b0, way_addr}, i);
      chk("init_way_din", {12'b0, way_din}, 32'd0);
      @(negedge clk);
    end
    #1;
    chk("init_then_ready", {31'b0, ready}, 32'd1);
    chk("line3_after_init", {12'b0, ways[3]}, 32'h0);

    // Clean read miss, then hit, write hit, dirty read miss.
    do_req(1'b0, 5'h0B, 16'h0000, 16'h1234, 1'b0, 3 + MEM_LAT);
    chk("line3_refill", {12'b0, ways[3]}, 32'h91234);
    do_req(1'b0, 5'h0B, 16'h0000, 16'h1234, 1'b1, 2);
    do_req(1'b1, 5'h0B, 16'hBEEF, 16'h0000, 1'b1, 2);
    chk("line3_write_hit", {12'b0, ways[3]}, 32'hDBEEF);
    wb_q.push_back('{a: 5'h0B, d: 16'hBEEF});
    do_req(1'b0, 5'h1B, 16'h0000, 16'h5678, 1'b0, 4 + MEM_LAT);
    chk("line3_after_wb", {12'b0, ways[3]}, 32'hB5678);
    chk("ram_0b_written_back", {16'b0, ram_rd(5'h0B)}, 32'hBEEF);

    // Clean write miss, then dirty write miss on the same index.
    do_req(1'b1, 5'h05, 16'h1111, 16'h0000, 1'b0, 3);
    chk("line5_alloc", {12'b0, ways[5]}, 32'hC1111);
    wb_q.push_back('{a: 5'h05, d: 16'h1111});
    do_req(1'b1, 5'h15, 16'h2222, 16'h0000, 1'b0, 4);
    chk("line5_dirty_alloc", {12'b0, ways[5]}, 32'hE2222);
    chk("ram_05_written_back", {16'b0, ram_rd(5'h05)}, 32'h1111);

    // Reset in the middle of a refill, with req held high throughout.
    wait_ready();
    req  = 1'b1;
    we   = 1'b0;
    addr = 5'h02;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("refill_mem_addr", {27'b0, mem_addr}, 32'h02);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_ready", {31'b0, ready}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_mem_we", {31'b0, mem_we}, 32'd0);
    rst = 1'b0;
    #1;
    chk("reinit_way_we", {31'b0, way_we}, 32'd1);
    chk("reinit_way_addr", {29'b0, way_addr}, 32'd0);
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("reinit_cycles", n, 32'd8);
    e = '{rdata: 16'hA5A5, hit: 1'b0, is_rd: 1'b1, acc: cyc + 1, lat: 3 + MEM_LAT};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req = 1'b0;
    wait_idle();
    chk("line2_refill", {12'b0, ways[2]}, 32'h8A5A5);
    chk("line3_cleared", {12'b0, ways[3]}, 32'h0);
    do_req(1'b0, 5'h02, 16'h0000, 16'hA5A5, 1'b1, 2);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
